// File: rtl/ksa_seq_pkg.sv
// Shared constants and state type for the KSA operand sequencer:
// register offsets, CTRL/STATUS bit positions and the FSM state enum.
package ksa_seq_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_OPERAND = 2'd1;
  localparam logic [1:0] REG_RESULT  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_START     = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_ACC_MODE  = 2;
  localparam int CTRL_SETTLE_LO = 8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ksa_operand_sequencer_if.sv
// Wishbone slave bus bundle for the KSA operand sequencer.
// Signal names keep the Caravel-style wbs_* naming seen from the slave side.
interface ksa_operand_sequencer_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/ksa_seq_wb_regs.sv
// Wishbone decode, single-cycle ack and register file (CTRL/OPERAND/RESULT/STATUS).
// Writes land on the same edge that raises ack; read data is registered alongside it.
module ksa_seq_wb_regs
  import ksa_seq_pkg::*;
#(
  parameter logic [31:0]         BASE_ADDR  = 32'h3000_0000,
  parameter int                  SETTLE_W   = 4,
  parameter logic [SETTLE_W-1:0] SETTLE_RST = SETTLE_W'(2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ksa_operand_sequencer_if.slave  wb,
  input  logic                    busy,
  input  logic                    capture_valid,
  input  logic [15:0]             capture_sum,
  input  logic                    capture_cout,
  input  logic                    done_clr,
  input  logic                    start_err,
  output logic                    start_pulse,
  output logic                    irq_en,
  output logic                    acc_mode,
  output logic [SETTLE_W-1:0]     settle,
  output logic [15:0]             op_a,
  output logic [15:0]             op_b,
  output logic [15:0]             result_sum,
  output logic                    done
);

  logic                ack_q, ack_d;
  logic [31:0]         rdat_q, rdat_d;
  logic                start_q, start_d;
  logic                irq_en_q, irq_en_d;
  logic                acc_mode_q, acc_mode_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [31:0]         operand_q, operand_d;
  logic [16:0]         result_q, result_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic       req, wr, rd;
  logic [1:0] idx;
  logic       unused_adr;

  assign unused_adr = ^wb.wbs_adr_i[1:0];

  assign req = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q &
               (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr  = req & wb.wbs_we_i;
  assign rd  = req & ~wb.wbs_we_i;
  assign idx = wb.wbs_adr_i[3:2];

  always_comb begin
    ack_d      = req;
    rdat_d     = '0;
    start_d    = 1'b0;
    irq_en_d   = irq_en_q;
    acc_mode_d = acc_mode_q;
    settle_d   = settle_q;
    operand_d  = operand_q;
    result_d   = result_q;
    done_d     = done_q;
    err_d      = err_q;

    if (rd) begin
      case (idx)
        REG_CTRL: begin
          rdat_d[CTRL_IRQ_EN]                = irq_en_q;
          rdat_d[CTRL_ACC_MODE]              = acc_mode_q;
          rdat_d[CTRL_SETTLE_LO +: SETTLE_W] = settle_q;
        end
        REG_OPERAND: rdat_d = operand_q;
        REG_RESULT:  rdat_d = {15'b0, result_q};
        REG_STATUS: begin
          rdat_d[STAT_BUSY] = busy;
          rdat_d[STAT_DONE] = done_q;
          rdat_d[STAT_ERR]  = err_q;
        end
        default: rdat_d = '0;
      endcase
    end

    if (wr) begin
      case (idx)
        REG_CTRL: begin
          if (wb.wbs_sel_i[0]) begin
            start_d    = wb.wbs_dat_i[CTRL_START];
            irq_en_d   = wb.wbs_dat_i[CTRL_IRQ_EN];
            acc_mode_d = wb.wbs_dat_i[CTRL_ACC_MODE];
          end
          if (wb.wbs_sel_i[1]) settle_d = wb.wbs_dat_i[CTRL_SETTLE_LO +: SETTLE_W];
        end
        REG_OPERAND: begin
          if (busy) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (wb.wbs_sel_i[i]) operand_d[8*i +: 8] = wb.wbs_dat_i[8*i +: 8];
            end
          end
        end
        REG_STATUS: begin
          if (wb.wbs_sel_i[0]) begin
            if (wb.wbs_dat_i[STAT_DONE]) done_d = 1'b0;
            if (wb.wbs_dat_i[STAT_ERR])  err_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Hardware events are applied last so a set always beats a same-cycle W1C.
    if (done_clr) done_d = 1'b0;
    if (capture_valid) begin
      done_d   = 1'b1;
      result_d = {capture_cout, capture_sum};
    end
    if (start_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      rdat_q     <= '0;
      start_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      acc_mode_q <= 1'b0;
      settle_q   <= SETTLE_RST;
      operand_q  <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      start_q    <= start_d;
      irq_en_q   <= irq_en_d;
      acc_mode_q <= acc_mode_d;
      settle_q   <= settle_d;
      operand_q  <= operand_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = rdat_q;
  assign start_pulse  = start_q;
  assign irq_en       = irq_en_q;
  assign acc_mode     = acc_mode_q;
  assign settle       = settle_q;
  assign op_a         = operand_q[15:0];
  assign op_b         = operand_q[31:16];
  assign result_sum   = result_q[15:0];
  assign done         = done_q;

endmodule

// File: rtl/ksa_operand_sequencer.sv
// Wishbone-fed operand sequencer for the 16-bit Kogge-Stone adder: drives a/b,
// waits a programmable settle window, then captures sum/cout and flags done.
module ksa_operand_sequencer
  import ksa_seq_pkg::*;
#(
  parameter logic [31:0]         BASE_ADDR  = 32'h3000_0000,
  parameter int                  SETTLE_W   = 4,
  parameter logic [SETTLE_W-1:0] SETTLE_RST = SETTLE_W'(2)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  ksa_operand_sequencer_if.slave wb,
  output logic [15:0]            add_a_o,
  output logic [15:0]            add_b_o,
  input  logic [15:0]            add_sum_i,
  input  logic                   add_cout_i,
  output logic                   irq_o
);

  seq_state_e          state_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic [15:0]         add_a_q, add_b_q;

  logic                start_pulse, irq_en, acc_mode, done;
  logic [SETTLE_W-1:0] settle;
  logic [15:0]         op_a, op_b, result_sum;
  logic                busy, capture_valid, done_clr, start_err;

  assign busy          = (state_q != IDLE);
  assign capture_valid = (state_q == CAPTURE);
  assign done_clr      = start_pulse & ~busy;
  assign start_err     = start_pulse & busy;

  ksa_seq_wb_regs #(
    .BASE_ADDR  (BASE_ADDR),
    .SETTLE_W   (SETTLE_W),
    .SETTLE_RST (SETTLE_RST)
  ) u_regs (
    .clk           (wb_clk_i),
    .rst_n         (wb_rst_ni),
    .wb            (wb),
    .busy          (busy),
    .capture_valid (capture_valid),
    .capture_sum   (add_sum_i),
    .capture_cout  (add_cout_i),
    .done_clr      (done_clr),
    .start_err     (start_err),
    .start_pulse   (start_pulse),
    .irq_en        (irq_en),
    .acc_mode      (acc_mode),
    .settle        (settle),
    .op_a          (op_a),
    .op_b          (op_b),
    .result_sum    (result_sum),
    .done          (done)
  );

  // OPERAND writes are locked out while busy, so sampling at LOAD sees the
  // same operands that were present when the start was accepted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_pulse) state_q <= LOAD;
        end
        LOAD: begin
          add_a_q <= acc_mode ? result_sum : op_a;
          add_b_q <= op_b;
          cnt_q   <= settle;
          state_q <= (settle == '0) ? CAPTURE : SETTLE;
        end
        SETTLE: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SETTLE_W'(1)) state_q <= CAPTURE;
        end
        CAPTURE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_a_o = add_a_q;
  assign add_b_o = add_b_q;
  assign irq_o   = done & irq_en;

endmodule

// File: tb/tb_ksa_operand_sequencer.sv
// Self-checking bench for ksa_operand_sequencer: behavioural adder on a/b,
// Wishbone master tasks, and a queue of expected read-back values.
module tb_ksa_operand_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst_n;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cout, irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  ksa_operand_sequencer_if wb ();

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  ksa_operand_sequencer #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb         (wb),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_sum_i  (add_sum),
    .add_cout_i (add_cout),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic bus_idle();
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
    int waited = 0;
    @(posedge clk); #1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!wb.wbs_ack_o && waited < 16);
    rdata = wb.wbs_dat_o;
    n_checks++;
    if (wb.wbs_ack_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ack_timeout adr=%h got ack=%b want 1", adr, wb.wbs_ack_o);
    end
    bus_idle();
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_access(1'b1, adr, dat, sel, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdata);
    wb_access(1'b0, adr, 32'h0, 4'hF, rdata);
  endtask

  // Counts cycles from the start-write ack cycle until irq_o rises (bounded).
  task automatic wait_irq(input int budget, inout int cycles);
    while (irq !== 1'b1 && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
    n_checks++;
    if (add_a !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_add_a got %h want 0000", add_a); end
    n_checks++;
    if (add_b !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_add_b got %h want 0000", add_b); end
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      wb_read(BASE + 32'(i * 4), d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin n_fail++; $display("[TB] FAIL reset_reg%0d got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_single_add();
    logic [31:0] d, e;
    int cycles = 0;
    wb_write(BASE + 32'h4, 32'h0001_FFFF, 4'hF);
    wb_write(BASE + 32'h0, 32'h0000_0003, 4'b0001);
    exp_q.push_back(32'h0001_0000);
    repeat (2) begin @(posedge clk); #1; cycles++; end
    n_checks++;
    if (add_a !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL single_add_a got %h want ffff", add_a); end
    n_checks++;
    if (add_b !== 16'h0001) begin n_fail++; $display("[TB] FAIL single_add_b got %h want 0001", add_b); end
    wait_irq(40, cycles);
    n_checks++;
    if (cycles !== 5) begin n_fail++; $display("[TB] FAIL single_latency got %0d want 5", cycles); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL single_irq got %b want 1", irq); end
    wb_read(BASE + 32'h8, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL single_result got %h want %h", d, e); end
    wb_write(BASE + 32'hC, 32'h2, 4'b0001);
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL single_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_accumulate();
    logic [31:0] d, e;
    logic [15:0] model_sum;
    int cycles;
    wb_write(BASE + 32'h0, 32'h0000_0002, 4'b0011);
    wb_write(BASE + 32'h4, 32'h1234_0000, 4'hF);
    model_sum = 16'h0;
    for (int i = 0; i < 3; i++) begin
      model_sum = ((i == 0) ? 16'h0000 : model_sum) + 16'h1234;
      exp_q.push_back({16'h0, model_sum});
      wb_write(BASE + 32'h0, (i == 0) ? 32'h3 : 32'h7, 4'b0001);
      cycles = 0;
      wait_irq(40, cycles);
      n_checks++;
      if (cycles !== 3) begin n_fail++; $display("[TB] FAIL acc_latency%0d got %0d want 3", i, cycles); end
      wb_read(BASE + 32'h8, d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin n_fail++; $display("[TB] FAIL acc_result%0d got %h want %h", i, d, e); end
      wb_write(BASE + 32'hC, 32'h2, 4'b0001);
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] d, e;
    int cycles = 0;
    wb_write(BASE + 32'h0, 32'h0000_0F02, 4'b0011);
    wb_write(BASE + 32'h4, 32'h0005_0003, 4'hF);
    wb_write(BASE + 32'h0, 32'h0000_0003, 4'b0001);
    wb_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF);
    wb_write(BASE + 32'h0, 32'h0000_0003, 4'b0001);
    exp_q.push_back(32'h0005_0003);
    exp_q.push_back(32'h0000_0008);
    exp_q.push_back(32'h0000_0006);
    exp_q.push_back(32'h0000_0000);
    wb_read(BASE + 32'h4, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL busy_operand got %h want %h", d, e); end
    wait_irq(60, cycles);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_irq got %b want 1", irq); end
    wb_read(BASE + 32'h8, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL busy_result got %h want %h", d, e); end
    wb_read(BASE + 32'hC, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL busy_status got %h want %h", d, e); end
    wb_write(BASE + 32'hC, 32'h6, 4'b0001);
    wb_read(BASE + 32'hC, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL busy_status_w1c got %h want %h", d, e); end
  endtask

  task automatic test_no_ack();
    int acks = 0;
    @(posedge clk); #1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = BASE + 32'h10;
    repeat (8) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("[TB] FAIL no_ack_count got %0d want 0", acks); end
    n_checks++;
    if (wb.wbs_dat_o !== 32'h0) begin n_fail++; $display("[TB] FAIL no_ack_data got %h want 0", wb.wbs_dat_o); end
    bus_idle();
  endtask

  task automatic test_byte_write();
    logic [31:0] d, e;
    wb_write(BASE + 32'h4, 32'h1111_2222, 4'hF);
    wb_write(BASE + 32'h4, 32'h5555_66AB, 4'b0001);
    exp_q.push_back(32'h1111_22AB);
    wb_read(BASE + 32'h4, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL byte_write got %h want %h", d, e); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d, e;
    int cycles = 0;
    wb_write(BASE + 32'h0, 32'h0000_0F02, 4'b0011);
    wb_write(BASE + 32'h4, 32'h0002_0003, 4'hF);
    wb_write(BASE + 32'h0, 32'h0000_0003, 4'b0001);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_irq got %b want 0", irq); end
    n_checks++;
    if (add_a !== 16'h0) begin n_fail++; $display("[TB] FAIL midrst_add_a got %h want 0000", add_a); end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0200);
    wb_read(BASE + 32'hC, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL midrst_status got %h want %h", d, e); end
    wb_read(BASE + 32'h8, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL midrst_result got %h want %h", d, e); end
    wb_read(BASE + 32'h0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL midrst_ctrl got %h want %h", d, e); end
    wb_write(BASE + 32'h4, 32'h0002_0003, 4'hF);
    wb_write(BASE + 32'h0, 32'h0000_0003, 4'b0001);
    exp_q.push_back(32'h0000_0005);
    wait_irq(40, cycles);
    n_checks++;
    if (cycles !== 5) begin n_fail++; $display("[TB] FAIL midrst_restart_latency got %0d want 5", cycles); end
    wb_read(BASE + 32'h8, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("[TB] FAIL midrst_restart_result got %h want %h", d, e); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_idle();
    test_reset();
    test_single_add();
    test_accumulate();
    test_busy_writes();
    test_no_ack();
    test_byte_write();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ksa_operand_sequencer.md
Name: ksa_operand_sequencer

Overview:
- Wishbone slave stage directly upstream of the 16-bit Kogge-Stone adder.
- Stages operand pairs from the management SoC and presents them on the adder's a/b inputs.
- Holds the operands stable for a programmable settle window, then captures sum/cout into a readable result register.
- Raises a done interrupt and supports an accumulate mode that feeds the captured sum back as the next A operand.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address; slave decodes adr[31:4] == BASE_ADDR[31:4].
- SETTLE_W, 4, width of the settle-cycle counter.
- SETTLE_RST, 4'd2, reset value of CTRL.settle (cycles operands are held before capture).

Ports:
- wb_clk_i  in  1  single clock for the block.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- add_a_o  out  16  operand A to adder.
- add_b_o  out  16  operand B to adder.
- add_sum_i  in  16  adder sum.
- add_cout_i  in  1  adder carry out.
- irq_o  out  1  level interrupt = STATUS.done & CTRL.irq_en.

Behaviour:
- Register map (adr[3:2]):
  - 0 CTRL: bit0 start (write-1 pulse, reads 0), bit1 irq_en, bit2 acc_mode, bits[11:8] settle.
  - 1 OPERAND: [15:0] A, [31:16] B.
  - 2 RESULT (RO): [15:0] sum, bit16 cout, rest 0.
  - 3 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 err (W1C).
- Wishbone access:
  - Access when stb & cyc & address match & !ack: ack asserts the next cycle for exactly one cycle. Back-to-back accesses therefore take 2 cycles each.
  - Non-matching address: no ack.
  - Writes honour wbs_sel_i per byte.
  - Read data is registered with the ack; a read with no ack drives 0.
- Reset: all outputs 0; CTRL = {settle=SETTLE_RST, others 0}; OPERAND, RESULT and STATUS = 0; FSM in IDLE.
- FSM:
  - IDLE: on start write, go to LOAD.
    - A operand = RESULT.sum if acc_mode, else OPERAND.A.
    - B operand = OPERAND.B.
    - busy = 1; done is cleared.
  - LOAD (1 cycle): register operands onto add_a_o/add_b_o; counter = settle.
  - SETTLE: hold operands; decrement counter each cycle; at 0, go to CAPTURE. settle = 0 means CAPTURE follows LOAD directly.
  - CAPTURE (1 cycle): RESULT <= {cout, sum}; done = 1; busy = 0; return to IDLE.
- Latency: start-write ack cycle to done visible = settle + 3 cycles.
- add_a_o/add_b_o keep their last values in IDLE; they change only in LOAD.
- Busy conditions:
  - Start write while busy is ignored and sets err.
  - OPERAND write while busy is dropped (register unchanged) and sets err.
  - CTRL.settle/irq_en writes while busy take effect immediately for irq_en. They are latched only at the next LOAD for settle; the running count is unaffected.
- Simultaneous events:
  - CAPTURE setting done in the same cycle as a W1C of done: set wins.
  - A start write in the same cycle CAPTURE completes counts as busy: ignored, err set.
- Reset mid-operation aborts immediately. No partial RESULT update; irq_o drops.

Decomposition:
- Shared package ksa_seq_pkg holds:
  - register offset constants (REG_CTRL = 2'd0 … REG_STATUS = 2'd3);
  - CTRL/STATUS bit-index constants;
  - FSM state enum (IDLE, LOAD, SETTLE, CAPTURE).
- One natural sub-module: ksa_seq_wb_regs, the Wishbone decode, ack and register file. The FSM stays in the top level.

Test Plan:
- Reset, then read all four registers: CTRL = 0x0000_0200, others 0; irq_o = 0; add_a_o = add_b_o = 0.
- Write OPERAND = 0x0001_FFFF, then CTRL = 0x3 (start, irq_en):
  - add_a_o = 0xFFFF and add_b_o = 0x0001 one cycle after LOAD;
  - done 5 cycles after the start ack;
  - RESULT = 0x0001_0000; irq_o = 1.
  - W1C STATUS = 0x2 clears irq_o.
- Accumulate, settle = 0:
  - Load OPERAND B = 0x1234 with A = 0x0000, start → RESULT 0x1234.
  - Set acc_mode, start twice → RESULT 0x2468, then 0x369C.
  - Each done arrives 3 cycles after start.
- Write OPERAND and start during SETTLE:
  - OPERAND unchanged; err = 1; the single run completes with the original operands.
- Access at BASE_ADDR + 0x10: no ack.
- Byte write sel = 4'b0001 of 0xAB to OPERAND holding 0x1111_2222 → 0x1111_22AB.
- Assert wb_rst_ni low during SETTLE → busy = 0, RESULT unchanged (0), FSM IDLE. A fresh start afterwards completes normally.
